// File: rtl/video_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_capture_ctrl
// Brief    : Frame sequencer between an 8-bit YUV422 ingest stream and the
//            tiling datapath. It aligns to start of frame, checks line and
//            frame geometry, and discards traffic while idle or after an error.
// Revision : 1.0 - initial release
// ============================================================================
module video_capture_ctrl #(
    parameter int LINE_BYTES  = 1440,
    parameter int FRAME_LINES = 240,
    parameter int CNT_W       = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] frame_count
);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_WAIT_SOF = 2'd1;
    localparam logic [1:0] c_S_CAPTURE  = 2'd2;
    localparam logic [1:0] c_S_DRAIN    = 2'd3;

    localparam logic [CNT_W-1:0] c_LAST_BYTE = CNT_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0] c_LAST_LINE = CNT_W'(FRAME_LINES - 1);

    logic [1:0]       r_state;
    logic             r_cont;
    logic             r_stop_pend;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_frame_count;
    logic [1:0]       r_err_code;
    logic             r_frame_done;
    logic             r_frame_err;

    logic             w_capture;
    logic             w_hunt;
    logic             w_stop_any;
    logic             w_keep_going;
    logic             w_hunt_exit;
    logic             w_take_sof;
    logic             w_pass;
    logic             w_beat;
    logic             w_early;
    logic [CNT_W-1:0] w_idx;
    logic [CNT_W-1:0] w_line;
    logic             w_at_last;
    logic             w_short;
    logic             w_long;
    logic             w_frame_end;
    logic [1:0]       w_next_state;

    assign w_capture    = (r_state == c_S_CAPTURE);
    assign w_hunt       = (r_state == c_S_WAIT_SOF) || (r_state == c_S_DRAIN);
    assign w_stop_any   = stop | r_stop_pend;
    assign w_keep_going = r_cont & ~w_stop_any;
    // DRAIN only resumes capture in continuous mode; single mode bails out.
    assign w_hunt_exit  = w_stop_any | ((r_state == c_S_DRAIN) & ~r_cont);

    // The SOF beat that ends a hunt is forwarded in the same cycle.
    assign w_take_sof = w_hunt & ~w_hunt_exit & s_axis_tvalid & s_axis_tuser;
    assign w_pass     = (w_capture & ~s_axis_tuser) | w_take_sof;
    assign w_early    = w_capture & s_axis_tvalid & s_axis_tuser;
    assign w_beat     = w_pass & s_axis_tvalid & m_axis_tready;

    assign w_idx       = w_capture ? r_byte_cnt : '0;
    assign w_line      = w_capture ? r_line_cnt : '0;
    assign w_at_last   = (w_idx == c_LAST_BYTE);
    assign w_short     = w_beat & s_axis_tlast & ~w_at_last;
    assign w_long      = w_beat & ~s_axis_tlast & w_at_last;
    assign w_frame_end = w_beat & s_axis_tlast & w_at_last & (w_line == c_LAST_LINE);

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = w_pass & s_axis_tvalid;
    assign m_axis_tlast  = s_axis_tlast | (w_pass & w_at_last);
    assign m_axis_tuser  = s_axis_tuser & w_pass;
    assign s_axis_tready = w_pass ? m_axis_tready : ~w_capture;

    always_comb begin
        w_next_state = r_state;
        if (r_state == c_S_IDLE) begin
            if (start && !stop) begin
                w_next_state = c_S_WAIT_SOF;
            end
        end else if (w_early) begin
            w_next_state = w_keep_going ? c_S_WAIT_SOF : c_S_IDLE;
        end else if (w_short || w_long) begin
            w_next_state = w_keep_going ? c_S_DRAIN : c_S_IDLE;
        end else if (w_frame_end) begin
            w_next_state = w_keep_going ? c_S_WAIT_SOF : c_S_IDLE;
        end else if (w_beat) begin
            w_next_state = c_S_CAPTURE;
        end else if (w_hunt && w_hunt_exit) begin
            w_next_state = c_S_IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= c_S_IDLE;
            r_cont        <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_byte_cnt    <= '0;
            r_line_cnt    <= '0;
            r_frame_count <= '0;
            r_err_code    <= 2'd0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_frame_done <= w_frame_end;
            r_frame_err  <= w_early | w_short | w_long;

            if (w_next_state == c_S_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if (stop) begin
                r_stop_pend <= 1'b1;
            end

            if ((r_state == c_S_IDLE) && start && !stop) begin
                r_cont     <= continuous;
                r_err_code <= 2'd0;
            end else if (w_early) begin
                r_err_code <= 2'd3;
            end else if (w_short) begin
                r_err_code <= 2'd1;
            end else if (w_long) begin
                r_err_code <= 2'd2;
            end

            if (w_frame_end) begin
                r_frame_count <= r_frame_count + CNT_W'(1);
            end

            if (w_beat) begin
                r_byte_cnt <= s_axis_tlast ? '0 : (w_idx + CNT_W'(1));
                r_line_cnt <= w_line + {{(CNT_W-1){1'b0}}, s_axis_tlast};
            end
        end
    end

    assign busy        = (r_state != c_S_IDLE);
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;
    assign err_code    = r_err_code;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_video_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_capture_ctrl
// Brief    : Scoreboard bench for video_capture_ctrl on an 8x4 geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_capture_ctrl;

    localparam int LB = 8;
    localparam int FL = 4;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [7:0]    s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
    logic [1:0]    err_code;
    logic [CW-1:0] frame_count;

    video_capture_ctrl #(
        .LINE_BYTES (LB),
        .FRAME_LINES(FL),
        .CNT_W      (CW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .start        (start),
        .continuous   (continuous),
        .stop         (stop),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .frame_count  (frame_count)
    );

    always #5 aclk = ~aclk;

    int         n_vec = 0;
    int         n_err = 0;
    int         done_seen = 0;
    int         err_seen = 0;
    logic [9:0] exp_q[$];
    bit         mt_rand = 1'b0;
    logic       mt_fixed = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: fixed or 50% random, updated just after each edge.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = mt_rand ? 1'($urandom_range(0, 1)) : mt_fixed;
        end
    end

    // Monitor: pops the scoreboard on every downstream handshake.
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    check("beat", int'({m_axis_tdata, m_axis_tlast, m_axis_tuser}),
                          int'(exp_q.pop_front()));
                end
            end
            if (frame_done) done_seen++;
            if (frame_err)  err_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic pulse_start(input logic cont);
        continuous = cont;
        start = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge aclk);
        #1;
        stop = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic user,
                        input bit fwd, input logic last_out);
        bit accepted;
        accepted = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        if (fwd) exp_q.push_back({d, last_out, user});
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge aclk);
            if (!fwd && i == 0) check("drop_ready", int'(s_axis_tready), 1);
            accepted = s_axis_tready;
            @(posedge aclk);
            #1;
        end
        if (!accepted) check("accept_timeout", int'(s_axis_tready), 1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // Beats k0..k1-1 of a well-formed frame; beat k sits at line k/LB.
    task automatic send_range(input int base, input bit fwd, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            send(8'(base + k), (k % LB) == LB - 1, k == 0, fwd, (k % LB) == LB - 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_s_tready", int'(s_axis_tready), 1);
        check("rst_m_tvalid", int'(m_axis_tvalid), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_pulses", int'({frame_done, frame_err}), 0);
        areset = 1'b0;
        idle(2);

        // 1) single frame
        pulse_start(1'b0);
        check("t1_busy_armed", int'(busy), 1);
        send_range(8'h00, 1'b1, 0, LB * FL);
        idle(2);
        check("t1_done", done_seen, 1);
        check("t1_count", int'(frame_count), 1);
        check("t1_busy", int'(busy), 0);

        // 2) armed mid-frame: pre-SOF beats dropped even with downstream stalled
        pulse_start(1'b0);
        mt_fixed = 1'b0;
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), i == 2, 1'b0, 1'b0, 1'b0);
        mt_fixed = 1'b1;
        send_range(8'h40, 1'b1, 0, LB * FL);
        idle(2);
        check("t2_done", done_seen, 2);
        check("t2_count", int'(frame_count), 2);

        // 3) short line on line 2, then continuous recapture
        pulse_start(1'b1);
        send_range(8'h10, 1'b1, 0, 2 * LB);
        for (int i = 0; i < 5; i++) send(8'h90 + 8'(i), i == 4, 1'b0, 1'b1, i == 4);
        idle(2);
        check("t3_err_code", int'(err_code), 1);
        check("t3_err_pulse", err_seen, 1);
        send_range(8'h10, 1'b0, 3 * LB, LB * FL);
        send_range(8'h60, 1'b1, 0, LB * FL);
        idle(2);
        check("t3_done", done_seen, 3);
        check("t3_count", int'(frame_count), 3);
        check("t3_err_sticky", int'(err_code), 1);
        check("t3_still_busy", int'(busy), 1);
        pulse_stop();
        check("t3_stop_idle", int'(busy), 0);

        // 4) long line: 8th beat gets forced tlast, beats 9-10 dropped
        pulse_start(1'b0);
        check("t4_err_cleared", int'(err_code), 0);
        for (int i = 0; i < 10; i++) begin
            send(8'hC0 + 8'(i), i == 9, i == 0, i < LB, i == LB - 1);
        end
        idle(2);
        check("t4_err_code", int'(err_code), 2);
        check("t4_err_pulse", err_seen, 2);
        check("t4_busy", int'(busy), 0);
        check("t4_count", int'(frame_count), 3);

        // 5) continuous with random downstream stalls
        pulse_start(1'b1);
        mt_rand = 1'b1;
        for (int f = 0; f < 3; f++) send_range(8'h20 * f + 8'h05, 1'b1, 0, LB * FL);
        idle(2);
        check("t5_done", done_seen, 6);
        check("t5_count", int'(frame_count), 6);

        // 6) stop mid-frame: the frame still completes, then IDLE
        send_range(8'h80, 1'b1, 0, 2 * LB);
        pulse_stop();
        check("t6_busy_pending", int'(busy), 1);
        send_range(8'h80, 1'b1, 2 * LB, LB * FL);
        mt_rand = 1'b0;
        idle(2);
        check("t6_done", done_seen, 7);
        check("t6_count", int'(frame_count), 7);
        check("t6_busy", int'(busy), 0);
        check("t6_err_code", int'(err_code), 0);

        // Early SOF: refused in CAPTURE, then restarts capture
        pulse_start(1'b1);
        send_range(8'h30, 1'b1, 0, LB + 3);
        send(8'hE0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        check("es_err_code", int'(err_code), 3);
        send_range(8'hE0, 1'b1, 1, LB * FL);
        idle(2);
        check("es_err_pulse", err_seen, 3);
        check("es_done", done_seen, 8);
        check("es_count", int'(frame_count), 8);
        pulse_stop();

        // Reset mid-line
        pulse_start(1'b0);
        send_range(8'h70, 1'b1, 0, 3);
        s_axis_tdata  = 8'h55;
        s_axis_tvalid = 1'b1;
        areset        = 1'b1;
        @(posedge aclk);
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_m_tvalid", int'(m_axis_tvalid), 0);
        check("mid_rst_s_tready", int'(s_axis_tready), 1);
        check("mid_rst_pulses", int'({frame_done, frame_err}), 0);
        check("mid_rst_count", int'(frame_count), 0);
        check("mid_rst_err_code", int'(err_code), 0);
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        idle(3);
        check("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
